// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register unit with a fixed-latency multiply sequencer for a MIPS core.
// Define HILO_ACC_EN to enable MADD/MADDU accumulation into {HI,LO}.
module mips_cpu_hilo_unit #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mult_start,
    input  logic        mult_sign,
    input  logic        mult_acc,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mfhi,
    input  logic        mflo,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_product,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [3:0] LAT  = 4'(MUL_LATENCY);

    // Handshake: a request (mult_start/mthi/mtlo/mfhi/mflo) is taken only in a
    // cycle where stall is low; while stall is high the caller must hold it.
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [63:0] capture_val;

`ifdef HILO_ACC_EN
    logic acc_r;

    // Accumulate wraps modulo 2^64, matching MADD/MADDU semantics.
    assign capture_val = acc_r ? ({hi, lo} + mul_product) : mul_product;
`else
    logic unused_acc;

    assign unused_acc  = mult_acc;
    assign capture_val = mul_product;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            mul_a    <= 32'd0;
            mul_b    <= 32'd0;
            mul_sign <= 1'b0;
            done     <= 1'b0;
`ifdef HILO_ACC_EN
            acc_r    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    // A same-cycle move is kept; the product overwrites it later.
                    if (mult_start) begin
                        mul_a    <= op_a;
                        mul_b    <= op_b;
                        mul_sign <= mult_sign;
`ifdef HILO_ACC_EN
                        acc_r    <= mult_acc;
`endif
                        cnt      <= LAT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        {hi, lo} <= capture_val;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign stall     = busy & (mfhi | mflo | mthi | mtlo | mult_start);
    assign dbg_state = state;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Self-checking bench for mips_cpu_hilo_unit: cycle-level reference model,
// directed literal cases and randomized traffic with a latency-true multiplier.
module tb_mips_cpu_hilo_unit;

    localparam int L = 2;
    localparam int PIDX = (L > 1) ? L - 2 : 0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mult_start, mult_sign, mult_acc;
    logic [31:0] op_a, op_b, wdata;
    logic        mthi, mtlo, mfhi, mflo;
    logic [31:0] mul_a, mul_b, hi, lo;
    logic        mul_sign, busy, done, stall;
    logic [63:0] mul_product;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mips_cpu_hilo_unit #(.MUL_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .mult_start(mult_start), .mult_sign(mult_sign),
        .mult_acc(mult_acc), .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .mfhi(mfhi), .mflo(mflo), .mul_a(mul_a), .mul_b(mul_b),
        .mul_sign(mul_sign), .mul_product(mul_product), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall), .dbg_state(dbg_state)
    );

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'd0, a};
        xb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // External multiplier: result valid L cycles after operands appear.
    logic [63:0] mp_pipe [0:14];
    logic [63:0] mp_comb;
    assign mp_comb = ref_mul(mul_a, mul_b, mul_sign);
    always @(posedge clk) begin
        mp_pipe[0] <= mp_comb;
        for (int i = 1; i < 15; i++) mp_pipe[i] <= mp_pipe[i-1];
    end
    assign mul_product = (L == 1) ? mp_comb : mp_pipe[PIDX];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: tracks the accept cycle of the multiply in flight.
    logic        m_ok = 1'b0;
    logic [31:0] m_hi, m_lo, m_ma, m_mb;
    logic        m_ms, m_acc, m_done, m_busy;
    int          m_t0 = -1;
    logic [63:0] m_sum;

    always @(negedge clk) begin
        m_busy = (m_t0 >= 0) && (cyc > m_t0) && (cyc <= m_t0 + L);
        if (m_ok) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("stall", 64'(stall), 64'(m_busy && (mfhi || mflo || mthi || mtlo || mult_start)));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("mul_a", 64'(mul_a), 64'(m_ma));
            chk("mul_b", 64'(mul_b), 64'(m_mb));
            chk("mul_sign", 64'(mul_sign), 64'(m_ms));
        end
        m_done = 1'b0;
        if (!reset_n) begin
            m_ok = 1'b1;
            {m_hi, m_lo, m_ma, m_mb} = '0;
            m_ms = 1'b0; m_acc = 1'b0; m_t0 = -1;
        end else if (m_busy) begin
            if (cyc == m_t0 + L) begin
                m_sum = ref_mul(m_ma, m_mb, m_ms);
`ifdef HILO_ACC_EN
                if (m_acc) m_sum = m_sum + {m_hi, m_lo};
`endif
                {m_hi, m_lo} = m_sum;
                m_done = 1'b1;
                m_t0 = -1;
            end
        end else begin
            if (mthi) m_hi = wdata;
            if (mtlo) m_lo = wdata;
            if (mult_start) begin
                m_ma = op_a; m_mb = op_b; m_ms = mult_sign; m_acc = mult_acc;
                m_t0 = cyc;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mult_start = 0; mult_sign = 0; mult_acc = 0; mthi = 0; mtlo = 0;
        mfhi = 0; mflo = 0;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s, input logic acc);
        mult_start = 1; op_a = a; op_b = b; mult_sign = s; mult_acc = acc;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 0; clr(); op_a = 0; op_b = 0; wdata = 0;
        repeat (3) next_cycle();
        reset_n = 1;
        next_cycle();
        mflo = 1; #1;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        clr();

        // Unsigned 3*5
        start(32'd3, 32'd5, 1'b0, 1'b0); #1;
        chk("a_busy0", 64'(busy), 64'h0);
        next_cycle(); clr(); #1;
        chk("a_busy1", 64'(busy), 64'h1);
        chk("a_mul_a", 64'(mul_a), 64'h3);
        chk("a_mul_b", 64'(mul_b), 64'h5);
        next_cycle(); #1;
        chk("a_busy2", 64'(busy), 64'h1);
        chk("a_done2", 64'(done), 64'h0);
        next_cycle(); #1;
        chk("a_busy3", 64'(busy), 64'h0);
        chk("a_hi", 64'(hi), 64'h0);
        chk("a_lo", 64'(lo), 64'hF);
        chk("a_done3", 64'(done), 64'h1);
        next_cycle(); #1;
        chk("a_done4", 64'(done), 64'h0);

        // Signed -1 * 2
        start(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        next_cycle(); clr(); #1;
        chk("b_sign1", 64'(mul_sign), 64'h1);
        next_cycle(); #1;
        chk("b_sign2", 64'(mul_sign), 64'h1);
        next_cycle(); #1;
        chk("b_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("b_lo", 64'(lo), 64'hFFFF_FFFE);
        chk("b_sign3", 64'(mul_sign), 64'h1);

        // mflo stalls while busy, mthi during busy is dropped
        next_cycle();
        start(32'd6, 32'd7, 1'b0, 1'b0);
        next_cycle(); clr(); mflo = 1; mthi = 1; wdata = 32'h1234; #1;
        chk("c_stall1", 64'(stall), 64'h1);
        next_cycle(); mthi = 0; #1;
        chk("c_stall2", 64'(stall), 64'h1);
        chk("c_hi_kept", 64'(hi), 64'hFFFF_FFFF);
        next_cycle(); #1;
        chk("c_stall3", 64'(stall), 64'h0);
        chk("c_hi", 64'(hi), 64'h0);
        chk("c_lo", 64'(lo), 64'h2A);
        clr();

        // Reset aborts a multiply
        next_cycle();
        start(32'd9, 32'd9, 1'b0, 1'b0);
        next_cycle(); clr(); reset_n = 0;
        next_cycle(); reset_n = 1; #1;
        chk("d_hi", 64'(hi), 64'h0);
        chk("d_lo", 64'(lo), 64'h0);
        chk("d_busy", 64'(busy), 64'h0);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); #1;
            chk("d_no_done", 64'(done), 64'h0);
        end
        chk("d_lo_end", 64'(lo), 64'h0);

        // Accumulate (or plain load when the feature is off)
        mtlo = 1; wdata = 32'hFFFF_FFFF;
        next_cycle(); clr();
        start(32'd1, 32'd1, 1'b0, 1'b1);
        next_cycle(); clr();
        repeat (L) next_cycle();
        #1;
`ifdef HILO_ACC_EN
        chk("e_hi", 64'(hi), 64'h1);
        chk("e_lo", 64'(lo), 64'h0);
`else
        chk("e_hi", 64'(hi), 64'h0);
        chk("e_lo", 64'(lo), 64'h1);
`endif

        // Same-cycle mthi and start
        next_cycle();
        mthi = 1; wdata = 32'hAA;
        start(32'h10, 32'h10, 1'b0, 1'b0);
        next_cycle(); clr(); #1;
        chk("f_hi_mthi", 64'(hi), 64'hAA);
        repeat (L) next_cycle();
        #1;
        chk("f_hi", 64'(hi), 64'h0);
        chk("f_lo", 64'(lo), 64'h100);
        chk("f_done", 64'(done), 64'h1);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset_n    = ($urandom_range(0, 99) != 0);
            mult_start = ($urandom_range(0, 3) == 0);
            mult_sign  = 1'($urandom_range(0, 1));
            mult_acc   = 1'($urandom_range(0, 1));
            mthi       = ($urandom_range(0, 7) == 0);
            mtlo       = ($urandom_range(0, 7) == 0);
            mfhi       = ($urandom_range(0, 3) == 0);
            mflo       = ($urandom_range(0, 3) == 0);
            op_a       = rnd_op();
            op_b       = rnd_op();
            wdata      = $urandom;
        end
        next_cycle();
        reset_n = 1; clr();
        repeat (L + 3) next_cycle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
